sipo_rx_ctrl: RTL



---
 rtl/sipo_pkg.sv | 16 +
 rtl/sipo_rx_ctrl_if.sv | 23 ++
 rtl/sipo_shreg.sv | 25 ++
 rtl/sipo_rx_ctrl.sv | 114 +++++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
// Shared types and constants for the serial-in/parallel-out receive path.
package sipo_pkg;

  localparam int WIDTH_DEFAULT = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Bit counter width for a frame of `width` bits (at least 1 bit wide).
  function automatic int cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/sipo_rx_ctrl_if.sv
// Parallel-word valid/ready channel from the frame controller to its consumer.
interface sipo_rx_ctrl_if #(
  parameter int WIDTH = sipo_pkg::WIDTH_DEFAULT
);
  logic [WIDTH-1:0] out_data;
  logic [WIDTH-1:0] out_data_n;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output out_data,
    output out_data_n,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_data_n,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/sipo_shreg.sv
// MSB-in shift register; `shifted` previews the word including this cycle's bit.
module sipo_shreg #(
  parameter int WIDTH = sipo_pkg::WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             d,
  output logic [WIDTH-1:0] shifted
);

  logic [WIDTH-1:0] q;

  assign shifted = {d, q[WIDTH-1:1]};

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (shift_en) begin
      q <= shifted;
    end
  end

endmodule

// File: rtl/sipo_rx_ctrl.sv
// Frame controller: qualifies serial bits, frames them into WIDTH-bit words
// and hands each word downstream over valid/ready with overrun/abort flags.
module sipo_rx_ctrl
  import sipo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          d,
  input  logic          bit_valid,
  input  logic          start,
  input  logic          clr_err,
  output logic          busy,
  output logic          overrun,
  output logic          frame_err,
  sipo_rx_ctrl_if.master rx
);

  localparam int CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             shift_en;
  logic             complete;
  logic             restart;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             load;
  logic             drop;

  sipo_shreg #(.WIDTH(WIDTH)) u_shreg (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .d        (d),
    .shifted  (shifted)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    shift_en   = 1'b0;
    complete   = 1'b0;
    restart    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bit_valid && start) begin
          shift_en   = 1'b1;
          cnt_next   = CNT_W'(1);
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_valid) begin
          shift_en = 1'b1;
          if (start) begin
            // A start always wins, even on the bit that would have completed the frame.
            restart  = 1'b1;
            cnt_next = CNT_W'(1);
          end else if (cnt == CNT_LAST) begin
            complete   = 1'b1;
            cnt_next   = '0;
            state_next = IDLE;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign load = complete && (!valid_q || rx.out_ready);
  assign drop = complete && valid_q && !rx.out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (load) begin
        data_q  <= shifted;
        valid_q <= 1'b1;
      end else if (valid_q && rx.out_ready) begin
        valid_q <= 1'b0;
      end
      // New error events take priority over a same-cycle clear.
      overrun   <= drop    || (overrun   && !clr_err);
      frame_err <= restart || (frame_err && !clr_err);
    end
  end

  assign busy          = (state == SHIFT);
  assign rx.out_data   = data_q;
  assign rx.out_data_n = ~data_q;
  assign rx.out_valid  = valid_q;

endmodule
